// File: rtl/rf_wb_arbiter.sv
// Register-file writeback arbiter: an ALU and a load channel, each buffered by a 2-entry FIFO.
// Define RF_WB_RR_EN for round-robin arbitration; the default build gives the load channel fixed priority.
module rf_wb_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   output logic        alu_ready,
   input  logic [4:0]  alu_a3,
   input  logic [31:0] alu_wd,
   input  logic        ld_valid,
   output logic        ld_ready,
   input  logic [4:0]  ld_a3,
   input  logic [31:0] ld_wd,
   input  logic [2:0]  ld_type,
   output logic [2:0]  RFWr,
   output logic [4:0]  A3,
   output logic [31:0] WD,
   input  logic [4:0]  qry_addr,
   output logic        qry_pending,
   output logic        type_err
);

   localparam int unsigned AW     = 5;
   localparam int unsigned DW     = 32;
   localparam int unsigned TW     = 3;
   localparam int unsigned NCH    = 2;
   localparam int unsigned DEPTH  = 2;
   localparam int unsigned CH_ALU = 0;
   localparam int unsigned CH_LD  = 1;

   typedef struct packed {
      logic [AW-1:0] a3;
      logic [DW-1:0] wd;
      logic [TW-1:0] typ;
   } wb_entry_t;

   wb_entry_t  mem    [NCH][DEPTH];
   logic [1:0] cnt    [NCH];
   logic       rd_ptr [NCH];
   logic       wr_ptr [NCH];

   wb_entry_t  in_entry [NCH];
   logic [NCH-1:0] push;
   logic [NCH-1:0] pop;
   logic [NCH-1:0] not_empty;
   logic       grant_ld;
   logic       any_grant;
   wb_entry_t  head;
   logic       head_illegal;
   logic       hit;

   // Ready comes from registered occupancy only, so a pop never opens a full FIFO early
   assign alu_ready = (cnt[CH_ALU] != 2'd2);
   assign ld_ready  = (cnt[CH_LD]  != 2'd2);

   always_comb begin
      in_entry[CH_ALU] = '{a3: alu_a3, wd: alu_wd, typ: 3'b001};
      in_entry[CH_LD]  = '{a3: ld_a3,  wd: ld_wd,  typ: ld_type};
      push             = {ld_valid && ld_ready, alu_valid && alu_ready};
      not_empty        = {cnt[CH_LD] != 2'd0, cnt[CH_ALU] != 2'd0};
   end

`ifdef RF_WB_RR_EN
   logic last_alu;

   // Remembers which channel won the previous grant; reset favours the load channel
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_alu <= 1'b1;
      end else if (any_grant) begin
         last_alu <= !grant_ld;
      end
   end

   always_comb begin
      if (not_empty[CH_LD] && not_empty[CH_ALU]) begin
         grant_ld = last_alu;
      end else begin
         grant_ld = not_empty[CH_LD];
      end
   end
`else
   always_comb begin
      grant_ld = not_empty[CH_LD];
   end
`endif

   always_comb begin
      any_grant    = |not_empty;
      pop          = {grant_ld, any_grant && !grant_ld};
      head         = grant_ld ? mem[CH_LD][rd_ptr[CH_LD]] : mem[CH_ALU][rd_ptr[CH_ALU]];
      head_illegal = (head.typ == 3'b000) || (head.typ > 3'b101);
   end

   // FIFO storage carries no reset; occupancy alone decides validity
   always_ff @(posedge clk) begin
      for (int unsigned c = 0; c < NCH; c++) begin
         if (push[c]) begin
            mem[c][wr_ptr[c]] <= in_entry[c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int unsigned c = 0; c < NCH; c++) begin
            cnt[c]    <= 2'd0;
            rd_ptr[c] <= 1'b0;
            wr_ptr[c] <= 1'b0;
         end
      end else begin
         for (int unsigned c = 0; c < NCH; c++) begin
            cnt[c]    <= cnt[c] + 2'(push[c]) - 2'(pop[c]);
            wr_ptr[c] <= wr_ptr[c] ^ push[c];
            rd_ptr[c] <= rd_ptr[c] ^ pop[c];
         end
      end
   end

   // Write-port register: a granted entry is issued unless it targets x0 or carries an illegal type
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         RFWr     <= 3'b000;
         A3       <= '0;
         WD       <= '0;
         type_err <= 1'b0;
      end else begin
         RFWr     <= 3'b000;
         type_err <= 1'b0;
         if (any_grant) begin
            if (head_illegal) begin
               type_err <= 1'b1;
            end else if (head.a3 != '0) begin
               RFWr <= head.typ;
               A3   <= head.a3;
               WD   <= head.wd;
            end
         end
      end
   end

   // Hazard query over queued entries and the write currently presented to the RF
   always_comb begin
      hit = 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            if (((cnt[c] == 2'd2) || ((cnt[c] == 2'd1) && (rd_ptr[c] == 1'(i))))
                && (mem[c][i].a3 == qry_addr)) begin
               hit = 1'b1;
            end
         end
      end
      if ((RFWr != 3'b000) && (A3 == qry_addr)) begin
         hit = 1'b1;
      end
      qry_pending = (qry_addr != '0) && hit;
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: directed stimulus queues hand-computed writes, a monitor checks them.
// Follows RF_WB_RR_EN to pick the expected grant order.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        alu_valid = 1'b0;
   logic        alu_ready;
   logic [4:0]  alu_a3 = '0;
   logic [31:0] alu_wd = '0;
   logic        ld_valid = 1'b0;
   logic        ld_ready;
   logic [4:0]  ld_a3 = '0;
   logic [31:0] ld_wd = '0;
   logic [2:0]  ld_type = 3'b001;
   logic [2:0]  RFWr;
   logic [4:0]  A3;
   logic [31:0] WD;
   logic [4:0]  qry_addr = '0;
   logic        qry_pending;
   logic        type_err;

   rf_wb_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_a3(alu_a3), .alu_wd(alu_wd),
      .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_a3(ld_a3), .ld_wd(ld_wd), .ld_type(ld_type),
      .RFWr(RFWr), .A3(A3), .WD(WD),
      .qry_addr(qry_addr), .qry_pending(qry_pending), .type_err(type_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  rfwr;
      logic [4:0]  a3;
      logic [31:0] wd;
      logic        terr;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_mon;
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic exp_write(input logic [2:0] t, input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back('{rfwr: t, a3: a, wd: d, terr: 1'b0});
   endtask

   task automatic exp_alu(input int i);
      exp_write(3'b001, 5'(10 + i), 32'hA000_0000 | 32'(i));
   endtask

   task automatic exp_ld(input int i);
      exp_write(3'b001, 5'(20 + i), 32'hB000_0000 | 32'(i));
   endtask

   // Every issued write or type error must match the head of the expected queue
   always @(negedge clk) begin
      if (!rst && (RFWr != 3'b000 || type_err)) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: RFWr=%b A3=%0d WD=0x%h type_err=%b, none expected",
                     RFWr, A3, WD, type_err);
         end else begin
            e_mon = exp_q.pop_front();
            check("wb_rfwr", 64'(RFWr), 64'(e_mon.rfwr));
            check("wb_type_err", 64'(type_err), 64'(e_mon.terr));
            if (e_mon.rfwr != 3'b000) begin
               check("wb_a3", 64'(A3), 64'(e_mon.a3));
               check("wb_wd", 64'(WD), 64'(e_mon.wd));
            end
         end
      end
   end

   task automatic do_reset();
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic end_test(input string name, input int cycles);
      repeat (cycles) @(negedge clk);
      check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
      exp_q.delete();
   endtask

   // Both channels offer every cycle for six cycles
   task automatic contention_test();
      logic [5:0] exp_ar, exp_lr;
      logic       exp_ar7;
      int         ai, li;
      logic       pa, pl;
`ifdef RF_WB_RR_EN
      exp_ar = 6'b101011;
      exp_lr = 6'b010111;
      exp_ar7 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_ld(i);
         exp_alu(i);
      end
`else
      exp_ar = 6'b000011;
      exp_lr = 6'b111111;
      exp_ar7 = 1'b0;
      for (int i = 0; i < 6; i++) exp_ld(i);
      exp_alu(0);
      exp_alu(1);
`endif
      ai = 0; li = 0; pa = 1'b0; pl = 1'b0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         @(negedge clk);
         if (cyc > 0) begin
            if (pa) ai++;
            if (pl) li++;
         end
         alu_valid = 1'b1; alu_a3 = 5'(10 + ai); alu_wd = 32'hA000_0000 | 32'(ai);
         ld_valid  = 1'b1; ld_a3  = 5'(20 + li); ld_wd  = 32'hB000_0000 | 32'(li);
         ld_type   = 3'b001;
         check($sformatf("cont_alu_ready_%0d", cyc), 64'(alu_ready), 64'(exp_ar[cyc]));
         check($sformatf("cont_ld_ready_%0d", cyc), 64'(ld_ready), 64'(exp_lr[cyc]));
         pa = alu_ready;
         pl = ld_ready;
      end
      @(negedge clk);
      alu_valid = 1'b0;
      ld_valid  = 1'b0;
      check("cont_alu_ready_after6", 64'(alu_ready), 64'd0);
      @(negedge clk);
      check("cont_alu_ready_after7", 64'(alu_ready), 64'(exp_ar7));
      end_test("cont", 6);
   endtask

   initial begin
      // Reset state, including ready held high while reset is asserted
      repeat (2) @(negedge clk);
      check("rst_alu_ready", 64'(alu_ready), 64'd1);
      check("rst_ld_ready", 64'(ld_ready), 64'd1);
      check("rst_rfwr", 64'(RFWr), 64'd0);
      check("rst_a3", 64'(A3), 64'd0);
      check("rst_wd", 64'(WD), 64'd0);
      check("rst_type_err", 64'(type_err), 64'd0);
      rst = 1'b0;

      // Single ALU push: one edge of latency, then RFWr returns to 000
      @(negedge clk);
      alu_valid = 1'b1; alu_a3 = 5'd5; alu_wd = 32'h1234_5678;
      exp_write(3'b001, 5'd5, 32'h1234_5678);
      @(negedge clk);
      alu_valid = 1'b0;
      check("single_lat_e1", 64'(RFWr), 64'd0);
      @(negedge clk);
      check("single_rfwr_e2", 64'(RFWr), 64'b001);
      check("single_a3_e2", 64'(A3), 64'd5);
      check("single_wd_e2", 64'(WD), 64'h1234_5678);
      @(negedge clk);
      check("single_idle_e3", 64'(RFWr), 64'd0);
      end_test("single", 3);

      do_reset();
      contention_test();

      // x0 target then illegal type: two empty slots, error only on the second
      do_reset();
      @(negedge clk);
      ld_valid = 1'b1; ld_a3 = 5'd0; ld_type = 3'b011; ld_wd = 32'hDEAD_0001;
      @(negedge clk);
      ld_a3 = 5'd7; ld_type = 3'b110; ld_wd = 32'hDEAD_0002;
      check("disc_rfwr_e1", 64'(RFWr), 64'd0);
      exp_q.push_back('{rfwr: 3'b000, a3: 5'd0, wd: 32'd0, terr: 1'b1});
      @(negedge clk);
      ld_valid = 1'b0; ld_type = 3'b001;
      check("disc_rfwr_e2", 64'(RFWr), 64'd0);
      check("disc_terr_e2", 64'(type_err), 64'd0);
      @(negedge clk);
      check("disc_rfwr_e3", 64'(RFWr), 64'd0);
      check("disc_terr_e3", 64'(type_err), 64'd1);
      @(negedge clk);
      check("disc_terr_e4", 64'(type_err), 64'd0);
      end_test("disc", 2);

      // Hazard query: ALU a3=9 alongside a load entry targeting x0
      do_reset();
      qry_addr = 5'd9;
      @(negedge clk);
      alu_valid = 1'b1; alu_a3 = 5'd9; alu_wd = 32'h0000_0099;
      ld_valid  = 1'b1; ld_a3  = 5'd0; ld_wd  = 32'h0000_0001; ld_type = 3'b001;
      exp_write(3'b001, 5'd9, 32'h0000_0099);
      #1 check("qry_same_cycle", 64'(qry_pending), 64'd0);
      @(negedge clk);
      alu_valid = 1'b0; ld_valid = 1'b0;
      check("qry_e1", 64'(qry_pending), 64'd1);
      qry_addr = 5'd0;
      #1 check("qry_zero_e1", 64'(qry_pending), 64'd0);
      qry_addr = 5'd9;
      @(negedge clk);
      check("qry_e2_queued", 64'(qry_pending), 64'd1);
      @(negedge clk);
      check("qry_e3_rfwr", 64'(RFWr), 64'b001);
      check("qry_e3", 64'(qry_pending), 64'd1);
      @(negedge clk);
      check("qry_e4", 64'(qry_pending), 64'd0);
      qry_addr = 5'd0;
      end_test("qry", 2);

      // Reset mid-operation with two entries still queued
      do_reset();
      @(negedge clk);
      alu_valid = 1'b1; alu_a3 = 5'd3; alu_wd = 32'h3333_3333;
      ld_valid  = 1'b1; ld_a3  = 5'd4; ld_wd  = 32'h4444_4444; ld_type = 3'b010;
      exp_write(3'b010, 5'd4, 32'h4444_4444);
      @(negedge clk);
      alu_valid = 1'b0;
      ld_a3 = 5'd6; ld_wd = 32'h6666_6666;
      @(negedge clk);
      ld_valid = 1'b0;
      check("mrst_pre_rfwr", 64'(RFWr), 64'b010);
      #2 rst = 1'b1;
      #1;
      check("mrst_rfwr", 64'(RFWr), 64'd0);
      check("mrst_a3", 64'(A3), 64'd0);
      check("mrst_wd", 64'(WD), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      check("mrst_alu_ready", 64'(alu_ready), 64'd1);
      check("mrst_ld_ready", 64'(ld_ready), 64'd1);
      end_test("mrst", 5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/rf_wb_arbiter.md
RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have ports alu_valid in 1, alu_ready out 1, alu_a3 in 5, alu_wd in 32: the ALU writeback request channel.
REQ-004 SHALL have ports ld_valid in 1, ld_ready out 1, ld_a3 in 5, ld_wd in 32, ld_type in 3: the load writeback request channel. ld_type codes: 001 lw, 010 lh, 011 lb, 100 lhu, 101 lbu.
REQ-005 SHALL have ports RFWr out 3, A3 out 5, WD out 32: the register-file write port, driven straight into the RF write inputs.
REQ-006 SHALL have ports qry_addr in 5, qry_pending out 1: the hazard query.
REQ-007 SHALL have port type_err, out, 1: a one-cycle pulse on each discarded illegal load type.

Function
REQ-008 SHALL contain one 2-entry FIFO per channel, holding {a3, wd, type}; ALU entries take type 001.
REQ-009 SHALL drive each xx_ready = FIFO not full, from registered state only, never from xx_valid.
REQ-010 SHALL enqueue at a rising edge where xx_valid and xx_ready are both 1.
REQ-011 SHALL block pushes while a FIFO is full, even if it pops on the same edge.
REQ-012 SHALL, on each edge, pop at most one FIFO head in total (the granted one) and load RFWr/A3/WD registers from it.
REQ-013 SHALL set RFWr <= 000 on an edge where both FIFOs are empty; A3/WD then hold their previous values.
REQ-014 SHALL give a latency of one edge from enqueue to output: an entry accepted at edge k appears on RFWr/A3/WD after edge k+1 at the earliest, and the RF writes it at edge k+2.
REQ-015 SHALL pop and discard a granted entry with a3 = 0, loading RFWr <= 000; a grant is still consumed.
REQ-016 SHALL accept an illegal ld_type (000, 110, 111), then on its grant discard it with RFWr <= 000 and type_err = 1 for that cycle.
REQ-017 SHALL keep arbitration per REQ-030/031, with the grant pointer updated on every grant.
REQ-018 SHALL preserve order within each channel (FIFO); no ordering guarantee applies between channels.
REQ-019 SHALL drive qry_pending = 1 iff qry_addr != 0 and it equals a3 of any valid FIFO entry, or RFWr != 000 and A3 == qry_addr. It is combinational, and same-cycle pushes are not included.
REQ-020 SHALL perform no sign or zero extension; WD carries raw data and the RF applies the extension selected by RFWr.

Reset
REQ-021 SHALL, on rst asserted asynchronously, empty both FIFOs; RFWr = 000, A3 = 0, WD = 0, type_err = 0.
REQ-022 SHALL, during reset, hold alu_ready = ld_ready = 1, so that they read 1 in the first cycle after release.
REQ-023 SHALL, during reset, set the grant pointer to "last granted = ALU", so the load channel wins first.
REQ-024 SHALL, on reset mid-operation, drop all queued entries without issuing any write; the output register clears immediately.

Configuration
REQ-030 SHALL, with RF_WB_RR_EN defined, arbitrate round-robin: when both heads are valid, grant the channel not granted last.
REQ-031 SHALL, without RF_WB_RR_EN, use fixed priority: the load channel always wins, and the pointer logic is absent.

Verification
REQ-040 SHALL cover: single ALU push a3 = 5, wd = 0x12345678 at edge 1 -> RFWr = 001, A3 = 5, WD = 0x12345678 after edge 2, and RFWr = 000 after edge 3.
REQ-041 SHALL cover: both channels push every cycle for 6 cycles with RR on -> grants alternate LD, ALU, LD, ..., and alu_ready/ld_ready drop to 0 once 2 entries are queued.
REQ-042 SHALL cover: the same stimulus with RR off -> all LD entries issue before any ALU entry, and the ALU FIFO holds 2 with alu_ready = 0.
REQ-043 SHALL cover: LD push a3 = 0, type 011, then a3 = 7, type 110 -> two consecutive RFWr = 000 slots, with type_err = 1 only on the second.
REQ-044 SHALL cover: ALU push a3 = 9, then qry_addr = 9 each cycle -> qry_pending = 1 from the cycle after the push until the cycle RFWr returns to 000; qry_addr = 0 always gives 0.
REQ-045 SHALL cover: 2 entries queued, then rst pulsed mid-cycle -> RFWr = 000 immediately, no write issued after release, and both readys = 1.
